serial_word_tx: RTL and testbench
=================================

Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter that drives the serial input of the team's bidirectional shift register / FIFO chain.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock.
- Bit order follows the dir convention. dir=1 sends MSB first, so the receiver shifting toward higher index ends with bit WIDTH-1 in its top stage. dir=0 sends LSB first.
- Emits start and done strobes so a receiver or controller can frame words.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..16.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  shift-enable; when 0, the shifter and counter hold.
- dir  input  1  bit order, sampled only at word accept: 1 = MSB first, 0 = LSB first.
- load_valid  input  1  upstream has a word on load_data.
- load_data  input  WIDTH  parallel word to send.
- load_ready  output  1  block can accept a word this cycle.
- S_out  output  1  serial data bit, registered.
- tx_active  output  1  high while a frame is on S_out.
- frame_start  output  1  one-cycle pulse in the cycle the first bit appears on S_out.
- done  output  1  one-cycle pulse in the cycle the last bit of a frame is on S_out.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State becomes IDLE.
  - Outputs: S_out=0, tx_active=0, frame_start=0, done=0, load_ready=1.
  - Shift register and bit counter are cleared; the latched dir becomes 1.
  - Reset mid-frame aborts the frame immediately, with no done pulse.
- States: IDLE and SHIFT.
- IDLE:
  - load_ready=1, tx_active=0, S_out=0.
  - Accept occurs when load_valid && load_ready at an edge; enable is not required for accept.
  - On accept, latch load_data and dir, set bits_left=WIDTH, and go to SHIFT.
  - The first bit is driven on S_out in the cycle after the accept edge (latency 1). frame_start=1 for that cycle.
- SHIFT:
  - S_out is the current head bit: shreg[WIDTH-1] if the latched dir=1, otherwise shreg[0].
  - At each edge with enable=1, shift one position toward the head and decrement bits_left.
  - At each edge with enable=0, hold everything; S_out is stable, and pending frame_start/done pulses are held, not dropped.
- Last bit (bits_left==1):
  - done=1.
  - load_ready=1 (back-to-back accept allowed).
- End of frame, at the last-bit edge with enable=1:
  - If load_valid=1, accept the new word, restart SHIFT with bits_left=WIDTH, and pulse frame_start next cycle. There is no idle gap, and the new dir is latched.
  - Otherwise go to IDLE; S_out returns to 0 next cycle.
- Last-bit edge with enable=0: no accept occurs, even if load_valid=1, and load_ready is forced to 0. This prevents a word being lost while stalled.
- Handshake: load_data and dir are ignored except at an accept edge. load_ready depends only on registered state and enable; it has no combinational path from load_valid.
- Frame length is exactly WIDTH enabled cycles (WIDTH+1 with the optional feature). bits_left never underflows.
- dir changes during SHIFT have no effect on the current frame.

Optional Feature:
- Macro: SERIAL_WORD_TX_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of all WIDTH data bits) is sent after the last data bit.
  - Frame length becomes WIDTH+1 and bits_left loads WIDTH+1.
  - done and back-to-back load_ready move to the parity cycle.
  - Parity is computed at accept and is independent of dir.
- Undefined: no parity stage; frame length is WIDTH.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, then release -> S_out=0, load_ready=1, tx_active=0, no pulses.
- MSB-first: WIDTH=4, dir=1, load 4'b1011, enable=1 -> S_out sequence 1,0,1,1 starting the cycle after accept; frame_start on bit 1, done on bit 4, then IDLE.
- LSB-first plus back-to-back: dir=0, load 4'b1011, then 4'b0110 with load_valid held -> S_out 1,1,0,1,0,1,1,0 with no gap; two frame_start and two done pulses.
- Stall: load 4'b1001 with dir=1, drop enable for 3 cycles after bit 2 -> S_out holds 0 for the stall, sequence completes as 1,0,0,1; load_ready=0 while stalled on the last bit.
- Reset mid-frame: load 4'b1111, assert reset after bit 2 -> next cycle S_out=0, no done pulse, load_ready=1; a subsequent word transmits correctly.
- Parity (SERIAL_WORD_TX_PARITY_EN defined): dir=1, load 4'b1011 -> S_out 1,0,1,1,1; done on the 5th bit.

Source files
------------

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter feeding the bidirectional shift-register chain; dir picks MSB/LSB first.
// Optional even-parity trailer bit when SERIAL_WORD_TX_PARITY_EN is defined; first bit appears one cycle after accept.
module serial_word_tx #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             dir,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             S_out,
   output logic             tx_active,
   output logic             frame_start,
   output logic             done
);

`ifdef SERIAL_WORD_TX_PARITY_EN
   localparam int FW = WIDTH + 1;
`else
   localparam int FW = WIDTH;
`endif
   localparam int CNT_W = $clog2(FW + 1);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FW);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   state_t            r_state, w_state_nx;
   logic [FW-1:0]     r_shreg, w_shreg_nx;
   logic [CNT_W-1:0]  r_bits,  w_bits_nx;
   logic              r_dir,   w_dir_nx;
   logic              w_last;
   logic              w_accept;
   logic [FW-1:0]     w_load_frame;

   // Parity always trails the data, so it sits at the tail end for either shift direction.
`ifdef SERIAL_WORD_TX_PARITY_EN
   assign w_load_frame = dir ? {load_data, ^load_data} : {^load_data, load_data};
`else
   assign w_load_frame = load_data;
`endif

   assign w_last      = (r_state == ST_SHIFT) && (r_bits == C_ONE);
   assign load_ready  = (r_state == ST_IDLE) || (w_last && enable);
   assign w_accept    = load_valid && load_ready;
   assign tx_active   = (r_state == ST_SHIFT);
   assign frame_start = (r_state == ST_SHIFT) && (r_bits == C_FULL);
   assign done        = w_last;
   assign S_out       = (r_state == ST_SHIFT) && (r_dir ? r_shreg[FW-1] : r_shreg[0]);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_shreg <= '0;
         r_bits  <= '0;
         r_dir   <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_shreg <= w_shreg_nx;
         r_bits  <= w_bits_nx;
         r_dir   <= w_dir_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_shreg_nx = r_shreg;
      w_bits_nx  = r_bits;
      w_dir_nx   = r_dir;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nx = ST_SHIFT;
               w_shreg_nx = w_load_frame;
               w_bits_nx  = C_FULL;
               w_dir_nx   = dir;
            end
         end
         ST_SHIFT: begin
            if (enable) begin
               if (w_last) begin
                  if (w_accept) begin
                     w_shreg_nx = w_load_frame;
                     w_bits_nx  = C_FULL;
                     w_dir_nx   = dir;
                  end else begin
                     w_state_nx = ST_IDLE;
                     w_shreg_nx = '0;
                     w_bits_nx  = '0;
                  end
               end else begin
                  w_shreg_nx = r_dir ? {r_shreg[FW-2:0], 1'b0} : {1'b0, r_shreg[FW-1:1]};
                  w_bits_nx  = r_bits - C_ONE;
               end
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: frame-level reference model checked every cycle, plus hand-computed literal sequences.
module tb_serial_word_tx;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b0;
   logic         dir = 1'b0;
   logic         load_valid = 1'b0;
   logic [W-1:0] load_data = '0;
   logic         load_ready, S_out, tx_active, frame_start, done;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on = 1'b0;

   serial_word_tx #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .S_out(S_out), .tx_active(tx_active), .frame_start(frame_start), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the frame is a list of bits in transmit order plus a position in it.
   bit m_active = 1'b0;
   bit m_bits[0:W];
   int m_len = W;
   int m_pos = 0;

   always @(posedge clk) begin
      bit rdy;
      if (!reset) begin
         m_active = 1'b0;
         m_pos    = 0;
      end else begin
         rdy = !m_active || (m_pos == m_len - 1 && enable);
         if (m_active && enable) begin
            if (m_pos == m_len - 1) m_active = 1'b0;
            else m_pos++;
         end
         if (load_valid && rdy) begin
            for (int i = 0; i < W; i++) m_bits[i] = dir ? load_data[W-1-i] : load_data[i];
`ifdef SERIAL_WORD_TX_PARITY_EN
            m_bits[W] = ^load_data;
            m_len = W + 1;
`else
            m_len = W;
`endif
            m_active = 1'b1;
            m_pos    = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model S_out",       S_out,       m_active ? m_bits[m_pos] : 1'b0);
         chk("model tx_active",   tx_active,   m_active);
         chk("model frame_start", frame_start, m_active && m_pos == 0);
         chk("model done",        done,        m_active && m_pos == m_len - 1);
         chk("model load_ready",  load_ready,  !m_active || (m_pos == m_len - 1 && enable));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (tx_active === 1'b1 && n < 60) begin
         tick();
         n++;
      end
      n_checks++;
      if (tx_active !== 1'b0) begin
         n_errors++;
         $display("FAIL wait_idle: tx_active still %b after %0d cycles", tx_active, n);
      end
   endtask

   initial begin
      logic [7:0] e;
      logic [3:0] wd [0:3];
      logic       wdir [0:3];

      // Reset held for two edges
      tick();
      chk_on = 1'b1;
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("rst S_out", S_out, 1'b0);
      chk("rst load_ready", load_ready, 1'b1);
      chk("rst tx_active", tx_active, 1'b0);
      chk("rst frame_start", frame_start, 1'b0);
      chk("rst done", done, 1'b0);

      // MSB first, 1011
      tick();
      enable = 1'b1; dir = 1'b1; load_data = 4'b1011; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      e = 8'b0000_1011;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("msb S_out", S_out, e[3-i]);
         chk("msb frame_start", frame_start, i == 0);
`ifndef SERIAL_WORD_TX_PARITY_EN
         chk("msb done", done, i == 3);
`endif
         tick();
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      @(negedge clk);
      chk("par S_out", S_out, 1'b1);
      chk("par done", done, 1'b1);
      tick();
`endif
      @(negedge clk);
      chk("msb idle tx_active", tx_active, 1'b0);
      chk("msb idle S_out", S_out, 1'b0);

`ifndef SERIAL_WORD_TX_PARITY_EN
      // LSB first, back-to-back 1011 then 0110
      tick();
      dir = 1'b0; load_data = 4'b1011; load_valid = 1'b1;
      tick();
      load_data = 4'b0110;
      e = 8'b0110_1011;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("b2b S_out", S_out, e[i]);
         chk("b2b frame_start", frame_start, i == 0 || i == 4);
         chk("b2b done", done, i == 3 || i == 7);
         tick();
         if (i == 3) load_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b idle tx_active", tx_active, 1'b0);

      // Stall mid-frame and on the last bit
      tick();
      dir = 1'b1; load_data = 4'b1001; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      @(negedge clk);
      chk("stall b0", S_out, 1'b1);
      tick();
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall b1 hold", S_out, 1'b0);
         tick();
         if (i == 2) enable = 1'b1;
      end
      @(negedge clk);
      chk("stall b2", S_out, 1'b0);
      tick();
      enable = 1'b0; load_valid = 1'b1; load_data = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("stall b3", S_out, 1'b1);
         chk("stall last done", done, 1'b1);
         chk("stall last load_ready", load_ready, 1'b0);
         tick();
      end
      enable = 1'b1; load_valid = 1'b0;
      @(negedge clk);
      chk("stall last ready en", load_ready, 1'b1);
      tick();
      @(negedge clk);
      chk("stall idle", tx_active, 1'b0);
`endif

      // Reset mid-frame
      tick();
      dir = 1'b1; load_data = 4'b1111; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("midrst S_out", S_out, 1'b0);
      chk("midrst done", done, 1'b0);
      chk("midrst load_ready", load_ready, 1'b1);
      chk("midrst tx_active", tx_active, 1'b0);
      tick();
      dir = 1'b0; load_data = 4'b0011; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      dir = 1'b1;
      e = 8'b0000_0011;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post-rst S_out", S_out, e[i]);
         tick();
      end
      wait_idle();

      // Held-valid stream with dir flips and enable gaps, model-checked
      wd[0] = 4'hA; wd[1] = 4'h5; wd[2] = 4'hC; wd[3] = 4'h7;
      wdir[0] = 1'b1; wdir[1] = 1'b0; wdir[2] = 1'b1; wdir[3] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         bit acc = 1'b0;
         load_data = wd[k]; dir = wdir[k]; load_valid = 1'b1;
         while (!acc && n < 40) begin
            @(negedge clk);
            acc = (load_ready === 1'b1);
            tick();
            enable = ((n % 3) != 1);
            n++;
         end
         n_checks++;
         if (!acc) begin
            n_errors++;
            $display("FAIL stream accept %0d: never ready", k);
         end
         dir = ~wdir[k];
      end
      load_valid = 1'b0;
      enable = 1'b1;
      wait_idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
